button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Front-end stage directly upstream of the stopwatch counter; conditions the five raw active-low push-buttons (Iniciar, Reset, Contar, Pausar, Parar).
- Per button: 2-FF synchronizer and debouncer.
- Clean active-low levels for direct connection to the counter's button inputs.
- Single-cycle press pulses, arbitrated by fixed priority, with post-command lockout, plus an encoded command bus.
- Runs at 50 MHz (counter's 0.1 s tick = 5,000,000 cycles).

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized level must differ from the debounced level before it is accepted (20 ms).
LOCKOUT_CYCLES, 2500000, cycles after an accepted command during which new press pulses are discarded (50 ms).
HOLD_CYCLES, 100000000, cycles Reset must stay debounced-low to fire hold_reset (2 s); used only with BTN_HOLD_EN.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset, synchronous, active-high
btn_raw_n  in  5  raw buttons, active-low; bit0 Iniciar, bit1 Reset, bit2 Contar, bit3 Pausar, bit4 Parar
btn_clean_n  out  5  debounced levels, active-low, same bit order
cmd_valid  out  1  one-cycle strobe: accepted command
cmd_code  out  3  0 none, 1 Iniciar, 2 Reset, 3 Contar, 4 Pausar, 5 Parar; nonzero only when cmd_valid=1
cmd_dropped  out  1  one-cycle strobe: at least one press pulse discarded (lost arbitration or lockout)
hold_reset  out  1  one-cycle strobe on long Reset press (BTN_HOLD_EN only)

Behaviour:
- Reset (rst=1 at edge):
  - sync FFs and btn_clean_n = 5'b11111.
  - All debounce, lockout and hold counters = 0.
  - cmd_valid, cmd_code, cmd_dropped, hold_reset = 0.
  - No strobe in the cycle after reset release.
  - Reset mid-debounce or mid-lockout aborts it completely.
- Synchronizer: sync1 <= btn_raw_n; sync2 <= sync1.
- Debounce, per bit i, each edge:
  - If sync2[i] == btn_clean_n[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: btn_clean_n[i] <= sync2[i], cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Counter width = clog2(DEBOUNCE_CYCLES).
  - Any bounce back to the accepted level restarts the count from 0.
- Press detect: press[i] = registered btn_clean_n[i] falling edge (1->0). Releases generate nothing.
- Latency: raw low first sampled by sync1 at edge 0 -> btn_clean_n low after edge DEBOUNCE_CYCLES+1 -> press visible, strobes high during the cycle after edge DEBOUNCE_CYCLES+2.
- Arbitration:
  - Priority Parar > Reset > Pausar > Contar > Iniciar.
  - Winner gives cmd_valid=1 with its code; losers are discarded (not queued) and cmd_dropped=1 in the same cycle.
- Lockout FSM:
  - States IDLE, LOCK.
  - IDLE: any press -> accept winner, go to LOCK, lock_cnt <= 0.
  - LOCK: lock_cnt increments each cycle; all presses discarded with cmd_dropped=1. When lock_cnt == LOCKOUT_CYCLES-1, go to IDLE.
  - A press in the first IDLE cycle after LOCK is accepted.
- btn_clean_n is not affected by lockout or arbitration.
- A button held through reset deassertion produces a press once debounced (clean level starts at 1).
- All outputs are registered.

Optional Feature:
Macro BTN_HOLD_EN.
- Defined:
  - hold_cnt increments while btn_clean_n[1] == 0 and saturates.
  - hold_reset pulses for exactly one cycle when hold_cnt reaches HOLD_CYCLES-1.
  - Holding further gives no repeat; hold_cnt clears on release.
  - hold_reset is independent of lockout.
- Undefined: hold_reset tied 0, no hold counter logic.

Test Plan:
(DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, HOLD_CYCLES=20)
1. btn_raw_n[2] low from edge 0, held -> btn_clean_n[2]=0 after edge 5; cmd_valid=1, cmd_code=3 for exactly one cycle after edge 6; no further strobes while held or on release.
2. btn_raw_n[0] low 3 cycles then high, repeated 5 times -> btn_clean_n stays 5'b11111; cmd_valid never 1.
3. btn_raw_n[1] and btn_raw_n[4] fall in the same cycle -> single strobe cmd_code=5 with cmd_dropped=1 in that cycle; code 2 never appears.
4. Press Contar, then Pausar debounced 3 cycles after the Contar strobe -> Pausar gives cmd_dropped=1 only. Release, then press Pausar again with its strobe after lockout ends -> cmd_code=4.
5. rst=1 for 1 cycle while btn_raw_n[3] is 2 cycles into debounce (raw kept low) -> outputs clear; the press strobes cmd_code=4 DEBOUNCE_CYCLES+2 edges after the first post-reset sample, not earlier.
6. BTN_HOLD_EN defined, Reset held 40 cycles -> one cmd_code=2 strobe and exactly one hold_reset pulse 20 cycles after btn_clean_n[1] falls. Undefined -> hold_reset=0 throughout.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions five raw active-low push-buttons (sync, debounce, press arbitration, lockout)
// for the stopwatch counter. Define BTN_HOLD_EN to add the long-press Reset strobe o_hold_reset.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LOCKOUT_CYCLES  = 2500000,
    parameter int HOLD_CYCLES     = 100000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_btn_raw_n,
    output logic [4:0] o_btn_clean_n,
    output logic       o_cmd_valid,
    output logic [2:0] o_cmd_code,
    output logic       o_cmd_dropped,
    output logic       o_hold_reset
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_INICIAR = 3'd1;
    localparam logic [2:0] CODE_RESET   = 3'd2;
    localparam logic [2:0] CODE_CONTAR  = 3'd3;
    localparam logic [2:0] CODE_PAUSAR  = 3'd4;
    localparam logic [2:0] CODE_PARAR   = 3'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    if (DEBOUNCE_CYCLES < 1 || LOCKOUT_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("button_conditioner: cycle-count parameters must be at least 1");
    end

    logic [4:0]        r_sync1;
    logic [4:0]        r_sync2;
    logic [4:0]        r_btn_clean_n;
    logic [4:0]        r_clean_d;
    logic [DB_W-1:0]   r_db_cnt [5];
    logic [0:0]        r_state;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_cmd_valid;
    logic [2:0]        r_cmd_code;
    logic              r_cmd_dropped;

    logic [4:0]        w_press;
    logic              w_any_press;
    logic              w_multi_press;
    logic [2:0]        w_win_code;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_btn_raw_n;
            r_sync2 <= r_sync1;
        end
    end

    // NOTE: the small per-button counter array is reset explicitly; it is flops, not a RAM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btn_clean_n <= '1;
            r_clean_d     <= '1;
            for (int i = 0; i < 5; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_clean_d <= r_btn_clean_n;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_btn_clean_n[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_btn_clean_n[i] <= r_sync2[i];
                    r_db_cnt[i]      <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is a debounced 1->0 transition; releases are ignored.
    assign w_press       = r_clean_d & ~r_btn_clean_n;
    assign w_any_press   = |w_press;
    assign w_multi_press = (w_press & (w_press - 5'd1)) != 5'd0;

    // NOTE: the default assignment first keeps this block from inferring a latch.
    always_comb begin
        w_win_code = CODE_NONE;
        if (w_press[4]) begin
            w_win_code = CODE_PARAR;
        end else if (w_press[1]) begin
            w_win_code = CODE_RESET;
        end else if (w_press[3]) begin
            w_win_code = CODE_PAUSAR;
        end else if (w_press[2]) begin
            w_win_code = CODE_CONTAR;
        end else if (w_press[0]) begin
            w_win_code = CODE_INICIAR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_lock_cnt    <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_code    <= CODE_NONE;
            r_cmd_dropped <= 1'b0;
        end else begin
            r_cmd_valid   <= 1'b0;
            r_cmd_code    <= CODE_NONE;
            r_cmd_dropped <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_press) begin
                        r_cmd_valid   <= 1'b1;
                        r_cmd_code    <= w_win_code;
                        r_cmd_dropped <= w_multi_press;
                        r_state       <= ST_LOCK;
                        r_lock_cnt    <= '0;
                    end
                end
                ST_LOCK: begin
                    // Every press during lockout is discarded, including in its final cycle.
                    r_cmd_dropped <= w_any_press;
                    if (r_lock_cnt == LOCK_LAST) begin
                        r_state    <= ST_IDLE;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

`ifdef BTN_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_hold_reset;

    // Parking the counter one past the fire value gives a single pulse per hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold_cnt   <= '0;
            r_hold_reset <= 1'b0;
        end else begin
            r_hold_reset <= 1'b0;
            if (r_btn_clean_n[1]) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt == HOLD_FIRE) begin
                r_hold_reset <= 1'b1;
                r_hold_cnt   <= HOLD_SAT;
            end else if (r_hold_cnt != HOLD_SAT) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign o_hold_reset = r_hold_reset;
`else
    assign o_hold_reset = 1'b0;
`endif

    assign o_btn_clean_n = r_btn_clean_n;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_code    = r_cmd_code;
    assign o_cmd_dropped = r_cmd_dropped;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected strobes are queued with their cycle number
// when stimulus is driven and compared every cycle against the registered outputs.
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int LOCK = 8;
    localparam int HOLD = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] raw;
    logic [4:0] o_btn_clean_n;
    logic       o_cmd_valid;
    logic [2:0] o_cmd_code;
    logic       o_cmd_dropped;
    logic       o_hold_reset;

    always #10 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCKOUT_CYCLES (LOCK),
        .HOLD_CYCLES    (HOLD)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_raw_n  (raw),
        .o_btn_clean_n(o_btn_clean_n),
        .o_cmd_valid  (o_cmd_valid),
        .o_cmd_code   (o_cmd_code),
        .o_cmd_dropped(o_cmd_dropped),
        .o_hold_reset (o_hold_reset)
    );

    typedef struct {
        int         cyc;
        logic       valid;
        logic [2:0] code;
        logic       dropped;
        logic       hold;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    exp_t mon_e;
    logic [5:0] mon_got;
    logic [5:0] mon_want;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the strobe pattern expected to be visible after edge number c.
    task automatic expect_at(input int c, input logic [2:0] code, input logic dropped,
                             input logic hold);
        exp_t e;
        e.cyc     = c;
        e.valid   = (code != 3'd0);
        e.code    = code;
        e.dropped = dropped;
        e.hold    = hold;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("sb_missed", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            mon_e.cyc     = cyc;
            mon_e.valid   = 1'b0;
            mon_e.code    = 3'd0;
            mon_e.dropped = 1'b0;
            mon_e.hold    = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) mon_e = sb.pop_front();
            mon_got  = {o_cmd_valid, o_cmd_code, o_cmd_dropped, o_hold_reset};
            mon_want = {mon_e.valid, mon_e.code, mon_e.dropped, mon_e.hold};
            check($sformatf("strobes@%0d", cyc), mon_got, mon_want);
        end
    end

    initial begin
        int n;
        raw = 5'h1f;
        rst = 1'b1;
        step(1);
        mon_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        check("reset_clean", o_btn_clean_n, 5'h1f);

        // Single Contar press held, then released: one strobe only.
        n = cyc;
        raw = 5'b11011;
        expect_at(n + 7, 3'd3, 1'b0, 1'b0);
        step(5);
        check("t1_clean_pre", o_btn_clean_n, 5'h1f);
        step(1);
        check("t1_clean_low", o_btn_clean_n, 5'b11011);
        step(24);
        raw = 5'h1f;
        step(12);
        check("t1_clean_rel", o_btn_clean_n, 5'h1f);

        // Bounces shorter than the debounce window never get accepted.
        for (int r = 0; r < 5; r++) begin
            raw = 5'b11110;
            step(3);
            raw = 5'h1f;
            step(2);
            check($sformatf("t2_clean_%0d", r), o_btn_clean_n, 5'h1f);
        end
        step(6);
        check("t2_clean_end", o_btn_clean_n, 5'h1f);

        // Reset and Parar together: Parar wins, Reset is dropped.
        n = cyc;
        raw = 5'b01101;
        expect_at(n + 7, 3'd5, 1'b1, 1'b0);
        step(10);
        raw = 5'h1f;
        step(20);

        // Pausar inside the lockout is dropped; pressed again afterwards it is accepted.
        n = cyc;
        raw = 5'b11011;
        expect_at(n + 7, 3'd3, 1'b0, 1'b0);
        step(3);
        raw = 5'b10011;
        expect_at(n + 10, 3'd0, 1'b1, 1'b0);
        step(9);
        raw = 5'h1f;
        step(8);
        raw = 5'b10111;
        expect_at(n + 27, 3'd4, 1'b0, 1'b0);
        step(10);
        raw = 5'h1f;
        step(20);

        // Lockout boundary: press on the last lock edge dropped, next edge accepted.
        n = cyc;
        raw = 5'b11011;
        expect_at(n + 7, 3'd3, 1'b0, 1'b0);
        step(8);
        raw = 5'b11010;
        expect_at(n + 15, 3'd0, 1'b1, 1'b0);
        step(1);
        raw = 5'b10010;
        expect_at(n + 16, 3'd4, 1'b0, 1'b0);
        step(10);
        raw = 5'h1f;
        step(20);

        // Reset two cycles into debounce: the press restarts from the first post-reset sample.
        n = cyc;
        raw = 5'b10111;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t5_clean_after_rst", o_btn_clean_n, 5'h1f);
        expect_at(n + 12, 3'd4, 1'b0, 1'b0);
        step(5);
        check("t5_clean_pre", o_btn_clean_n, 5'h1f);
        step(5);
        raw = 5'h1f;
        step(20);

        // Long Reset press: one command, and a single hold pulse when the feature is built in.
        n = cyc;
        raw = 5'b11101;
        expect_at(n + 7, 3'd2, 1'b0, 1'b0);
`ifdef BTN_HOLD_EN
        expect_at(n + 26, 3'd0, 1'b0, 1'b1);
`endif
        step(40);
        raw = 5'h1f;
        step(20);
        check("t6_clean_rel", o_btn_clean_n, 5'h1f);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
